// File: rtl/mwstage.sv
// Memory stage and M->W pipeline register: runs loads/stores over a req/ack bus,
// stalls upstream while an access is outstanding, and aborts accesses that never get acked.
`timescale 1ns/1ps
module mwstage #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        regw_M,
  input  logic        memw_M,
  input  logic        regmem_M,
  input  logic [3:0]  regScr_M,
  input  logic [31:0] ALUrslt_M,
  input  logic [31:0] address_M,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall_M,
  output logic        regw_W,
  output logic        regmem_W,
  output logic [3:0]  regScr_W,
  output logic [31:0] ALUrslt_W,
  output logic [31:0] rdata_W,
  output logic        bus_fault
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);
  localparam logic [CntW-1:0] CntMax  = '1;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic            w_memop, w_start, w_ack, w_timeout, w_wait;

  logic        r_req, r_we, r_regw, r_fault;
  logic [31:0] r_addr, r_wdata, r_alu;
  logic [3:0]  r_scr;

  logic        r_w_regw, r_w_regmem;
  logic [3:0]  r_w_scr;
  logic [31:0] r_w_alu, r_w_rdata;

  always_comb begin
    w_memop   = memw_M | regmem_M;
    w_start   = 1'b0;
    w_ack     = 1'b0;
    w_timeout = 1'b0;
    w_wait    = 1'b0;
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_memop) begin
          w_start   = 1'b1;
          w_state_d = StBusy;
          w_cnt_d   = '0;
        end
      end
      StBusy: begin
        // An ack in the last allowed cycle still completes the access.
        if (mem_ack) begin
          w_ack     = 1'b1;
          w_state_d = StIdle;
        end else if (r_cnt == CntLast) begin
          w_timeout = 1'b1;
          w_state_d = StIdle;
        end else begin
          w_wait = 1'b1;
          if (r_cnt != CntMax) w_cnt_d = r_cnt + CntW'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign stall_M = w_start | w_wait;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Bus side: request fields are captured once and held until ack or abort.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_regw  <= 1'b0;
      r_scr   <= '0;
      r_alu   <= '0;
      r_fault <= 1'b0;
    end else begin
      if (w_start) begin
        r_req   <= 1'b1;
        r_we    <= memw_M;
        r_addr  <= {address_M[31:2], 2'b00};
        r_wdata <= ALUrslt_M;
        r_regw  <= regw_M & ~memw_M;
        r_scr   <= regScr_M;
        r_alu   <= ALUrslt_M;
      end else if (w_ack || w_timeout) begin
        r_req <= 1'b0;
      end
      if (w_timeout) r_fault <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_w_regw   <= 1'b0;
      r_w_regmem <= 1'b0;
      r_w_scr    <= '0;
      r_w_alu    <= '0;
      r_w_rdata  <= '0;
    end else if (stall_M) begin
      r_w_regw   <= 1'b0;
      r_w_regmem <= 1'b0;
    end else if (w_ack) begin
      r_w_regw   <= r_regw;
      r_w_regmem <= ~r_we;
      r_w_scr    <= r_scr;
      r_w_alu    <= r_alu;
      r_w_rdata  <= r_we ? 32'h0 : mem_rdata;
    end else if (w_timeout) begin
      r_w_regw   <= 1'b0;
      r_w_regmem <= 1'b0;
      r_w_rdata  <= '0;
    end else begin
      r_w_regw   <= regw_M;
      r_w_regmem <= 1'b0;
      r_w_scr    <= regScr_M;
      r_w_alu    <= ALUrslt_M;
      r_w_rdata  <= '0;
    end
  end

  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign bus_fault = r_fault;
  assign regw_W    = r_w_regw;
  assign regmem_W  = r_w_regmem;
  assign regScr_W  = r_w_scr;
  assign ALUrslt_W = r_w_alu;
  assign rdata_W   = r_w_rdata;

endmodule

// File: tb/tb_mwstage.sv
// Directed bench for mwstage: table of pass-through ALU ops plus hand-written
// load/store, back-to-back, timeout and mid-access reset sequences.
`timescale 1ns/1ps
module tb_mwstage;

  logic        clk, rst;
  logic        regw_M, memw_M, regmem_M;
  logic [3:0]  regScr_M;
  logic [31:0] ALUrslt_M, address_M;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall_M, regw_W, regmem_W, bus_fault;
  logic [3:0]  regScr_W;
  logic [31:0] ALUrslt_W, rdata_W;

  int n_cmp = 0;
  int n_err = 0;

  mwstage #(.TIMEOUT_CYC(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .regw_M    (regw_M),
    .memw_M    (memw_M),
    .regmem_M  (regmem_M),
    .regScr_M  (regScr_M),
    .ALUrslt_M (ALUrslt_M),
    .address_M (address_M),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .stall_M   (stall_M),
    .regw_W    (regw_W),
    .regmem_W  (regmem_W),
    .regScr_W  (regScr_W),
    .ALUrslt_W (ALUrslt_W),
    .rdata_W   (rdata_W),
    .bus_fault (bus_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        regw;
    logic [3:0]  scr;
    logic [31:0] alu;
    logic        exp_regw;
    logic [3:0]  exp_scr;
    logic [31:0] exp_alu;
  } vec_t;

  vec_t vecs [4];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic rw, input logic mw, input logic rm, input logic [3:0] scr,
                       input logic [31:0] alu, input logic [31:0] addr);
    regw_M    = rw;
    memw_M    = mw;
    regmem_M  = rm;
    regScr_M  = scr;
    ALUrslt_M = alu;
    address_M = addr;
  endtask

  task automatic load_fast(input logic [3:0] scr, input logic [31:0] addr,
                           input logic [31:0] data);
    drive(1'b1, 1'b0, 1'b1, scr, 32'h0, addr);
    step();
    mem_ack   = 1'b1;
    mem_rdata = data;
    step();
    mem_ack = 1'b0;
    chk32("fast load rdata_W", rdata_W, data);
    chk1("fast load regmem_W", regmem_W, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    int   nstall;
    logic [3:0] pat;

    vecs[0] = '{1'b1, 4'h3, 32'h0000FFFF, 1'b1, 4'h3, 32'h0000FFFF};
    vecs[1] = '{1'b0, 4'hA, 32'h80000001, 1'b0, 4'hA, 32'h80000001};
    vecs[2] = '{1'b1, 4'hF, 32'hFFFFFFFF, 1'b1, 4'hF, 32'hFFFFFFFF};
    vecs[3] = '{1'b1, 4'h6, 32'hCAFEF00D, 1'b1, 4'h6, 32'hCAFEF00D};

    rst       = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk1("reset mem_req", mem_req, 1'b0);
    chk32("reset mem_addr", mem_addr, 32'h0);
    chk1("reset regw_W", regw_W, 1'b0);
    chk32("reset ALUrslt_W", ALUrslt_W, 32'h0);
    chk1("reset bus_fault", bus_fault, 1'b0);
    chk1("reset stall_M", stall_M, 1'b0);
    rst = 1'b1;

    // ALU pass-through, one-cycle latency
    for (int i = 0; i < 4; i++) begin
      drive(vecs[i].regw, 1'b0, 1'b0, vecs[i].scr, vecs[i].alu, 32'h0);
      #1;
      chk1("alu stall_M", stall_M, 1'b0);
      step();
      chk1("alu regw_W", regw_W, vecs[i].exp_regw);
      chk32("alu regScr_W", 32'(regScr_W), 32'(vecs[i].exp_scr));
      chk32("alu ALUrslt_W", ALUrslt_W, vecs[i].exp_alu);
      chk1("alu regmem_W", regmem_W, 1'b0);
      chk1("alu stall_M after", stall_M, 1'b0);
    end

    // Load acked in the fourth BUSY cycle
    drive(1'b1, 1'b0, 1'b1, 4'h5, 32'h11111111, 32'h00010004);
    #1;
    nstall = stall_M ? 1 : 0;
    chk1("load req before busy", mem_req, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      if (stall_M) nstall++;
      chk1("load mem_req", mem_req, 1'b1);
      chk32("load mem_addr", mem_addr, 32'h00010004);
      chk1("load mem_we", mem_we, 1'b0);
      chk1("load bubble regw_W", regw_W, 1'b0);
    end
    step();
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    #1;
    if (stall_M) nstall++;
    chk32("load stall cycles", 32'(nstall), 32'd4);
    step();
    mem_ack = 1'b0;
    chk1("load regmem_W", regmem_W, 1'b1);
    chk32("load rdata_W", rdata_W, 32'hDEADBEEF);
    chk1("load regw_W", regw_W, 1'b1);
    chk32("load regScr_W", 32'(regScr_W), 32'h5);
    chk1("load req after ack", mem_req, 1'b0);

    // Store to unaligned address
    drive(1'b1, 1'b1, 1'b0, 4'h7, 32'h12345678, 32'h00000007);
    step();
    chk1("store mem_we", mem_we, 1'b1);
    chk32("store mem_addr", mem_addr, 32'h00000004);
    chk32("store mem_wdata", mem_wdata, 32'h12345678);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk1("store regw_W", regw_W, 1'b0);
    chk32("store rdata_W", rdata_W, 32'h0);

    // Ack in IDLE must not disturb anything
    drive(1'b1, 1'b0, 1'b0, 4'h9, 32'h00000055, 32'h0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk1("idle ack mem_req", mem_req, 1'b0);
    chk32("idle ack ALUrslt_W", ALUrslt_W, 32'h00000055);

    // Back-to-back load then store (store also has regmem_M set)
    drive(1'b1, 1'b0, 1'b1, 4'h2, 32'h0, 32'h00000100);
    #1 pat[3] = stall_M;
    step();
    chk32("b2b load addr", mem_addr, 32'h00000100);
    mem_ack   = 1'b1;
    mem_rdata = 32'hA5A5A5A5;
    #1 pat[2] = stall_M;
    step();
    mem_ack = 1'b0;
    chk32("b2b load rdata_W", rdata_W, 32'hA5A5A5A5);
    drive(1'b1, 1'b1, 1'b1, 4'h4, 32'h0BADF00D, 32'h00000208);
    #1 pat[1] = stall_M;
    step();
    chk1("b2b store mem_we", mem_we, 1'b1);
    chk32("b2b store addr", mem_addr, 32'h00000208);
    chk32("b2b store wdata", mem_wdata, 32'h0BADF00D);
    mem_ack = 1'b1;
    #1 pat[0] = stall_M;
    step();
    mem_ack = 1'b0;
    chk32("b2b stall pattern", 32'(pat), 32'hA);
    chk1("b2b store regmem_W", regmem_W, 1'b0);
    chk1("b2b store regw_W", regw_W, 1'b0);

    // Timeout after 4 BUSY cycles
    load_fast(4'h1, 32'h00000040, 32'h77777777);
    step();
    drive(1'b1, 1'b0, 1'b1, 4'h8, 32'h0, 32'h00000300);
    step();
    for (int i = 0; i < 3; i++) begin
      chk1("to stall_M busy", stall_M, 1'b1);
      chk1("to mem_req busy", mem_req, 1'b1);
      step();
    end
    chk1("to stall_M last", stall_M, 1'b0);
    chk1("to mem_req last", mem_req, 1'b1);
    chk1("to bus_fault early", bus_fault, 1'b0);
    step();
    chk1("to mem_req dropped", mem_req, 1'b0);
    chk1("to bus_fault", bus_fault, 1'b1);
    chk1("to regw_W", regw_W, 1'b0);
    chk1("to regmem_W", regmem_W, 1'b0);
    chk32("to rdata_W", rdata_W, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    load_fast(4'h2, 32'h00000500, 32'h13579BDF);
    chk1("to bus_fault sticky", bus_fault, 1'b1);

    // Asynchronous reset in the middle of BUSY
    drive(1'b1, 1'b0, 1'b0, 4'hC, 32'hABCD0123, 32'h0);
    step();
    drive(1'b1, 1'b0, 1'b1, 4'hD, 32'h0, 32'h00000400);
    step();
    step();
    chk32("rst pre ALUrslt_W", ALUrslt_W, 32'hABCD0123);
    chk1("rst pre mem_req", mem_req, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk1("rst mem_req", mem_req, 1'b0);
    chk32("rst mem_addr", mem_addr, 32'h0);
    chk32("rst regScr_W", 32'(regScr_W), 32'h0);
    chk32("rst ALUrslt_W", ALUrslt_W, 32'h0);
    chk1("rst bus_fault", bus_fault, 1'b0);
    chk1("rst stall_M follows inputs", stall_M, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    chk1("post rst stall_M", stall_M, 1'b1);
    step();
    chk1("post rst mem_req", mem_req, 1'b1);
    chk32("post rst mem_addr", mem_addr, 32'h00000400);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0F0F0F0F;
    step();
    mem_ack = 1'b0;
    chk32("post rst rdata_W", rdata_W, 32'h0F0F0F0F);
    chk32("post rst regScr_W", 32'(regScr_W), 32'hD);
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
